// File: rtl/priority_encoder_rr_if.sv
// Request/grant bundle for priority_encoder_rr: request side in, registered
// grant and pending set out.
interface priority_encoder_rr_if #(
   parameter int N = 8
) ();
   localparam int W = $clog2(N);

   logic         enable;
   logic         clear;
   logic [N-1:0] req;
   logic         out_ready;
   logic         out_valid;
   logic [W-1:0] out_idx;
   logic [N-1:0] pending;

   modport master (
      output enable, clear, req, out_ready,
      input  out_valid, out_idx, pending
   );

   modport slave (
      input  enable, clear, req, out_ready,
      output out_valid, out_idx, pending
   );
endinterface

// File: rtl/priority_encoder_rr.sv
// Priority encoder with a registered grant output, a pending-request set and
// a selectable fixed-priority or round-robin policy.
module priority_encoder_rr #(
   parameter int N    = 8,
   parameter int MODE = 0
) (
   input logic                  clk,
   input logic                  rst_n,
   priority_encoder_rr_if.slave bus
);
   localparam int W = $clog2(N);

   logic [N-1:0] pending_r;
   logic         out_valid_r;
   logic [W-1:0] out_idx_r;
   logic [W-1:0] last_r;

   logic [N-1:0] cand_s;
   logic         load_s;
   logic [W-1:0] fp_sel_s;
   logic [W-1:0] rr_sel_s;
   logic [W-1:0] probe_s;
   logic         found_s;
   logic [W-1:0] sel_s;
   logic [N-1:0] grant_mask_s;

   function automatic logic [W-1:0] highest_set(input logic [N-1:0] v);
      logic [W-1:0] idx;
      idx = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         idx = v[i] ? W'(i) : idx;
      end
      return idx;
   endfunction

   // Candidate set and load condition for this cycle.
   always_comb begin
      cand_s = pending_r | (bus.enable ? bus.req : {N{1'b0}});
      load_s = !out_valid_r || bus.out_ready;
   end

   // Round-robin search upward from last+1; W-bit arithmetic wraps N-1 to 0.
   always_comb begin
      rr_sel_s = {W{1'b0}};
      found_s  = 1'b0;
      probe_s  = {W{1'b0}};
      for (int i = 0; i < N; i++) begin
         probe_s  = last_r + W'(1) + W'(i);
         rr_sel_s = (cand_s[probe_s] && !found_s) ? probe_s : rr_sel_s;
         found_s  = found_s | cand_s[probe_s];
      end
   end

   // Policy selection and the one-hot mask of the granted bit.
   always_comb begin
      fp_sel_s = highest_set(cand_s);
      case (MODE)
         1:       sel_s = rr_sel_s;
         default: sel_s = fp_sel_s;
      endcase
      grant_mask_s = {{(N-1){1'b0}}, 1'b1} << sel_s;
   end

   // Grant register, pending set and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_r   <= {N{1'b0}};
         out_valid_r <= 1'b0;
         out_idx_r   <= {W{1'b0}};
         last_r      <= W'(N - 1);
      end else if (bus.clear) begin
         pending_r   <= {N{1'b0}};
         out_valid_r <= 1'b0;
      end else if (load_s) begin
         if (cand_s != {N{1'b0}}) begin
            out_idx_r   <= sel_s;
            out_valid_r <= 1'b1;
            pending_r   <= cand_s & ~grant_mask_s;
            last_r      <= sel_s;
         end else begin
            out_valid_r <= 1'b0;
            pending_r   <= {N{1'b0}};
         end
      end else begin
         // Stalled: the held grant stays put while new requests accumulate.
         pending_r <= cand_s;
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.out_idx   = out_idx_r;
   assign bus.pending   = pending_r;
endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed bench for priority_encoder_rr: one fixed-priority and one
// round-robin instance, expected per-cycle state checked through a queue.
module tb_priority_encoder_rr;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct {
      int         dut;
      logic       valid;
      logic [2:0] idx;
      logic [7:0] pend;
   } exp_t;

   exp_t sb_q[$];
   int   step_no;

   priority_encoder_rr_if #(.N(8)) ifa ();
   priority_encoder_rr_if #(.N(8)) ifb ();

   priority_encoder_rr #(.N(8), .MODE(0)) dut_fp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa.slave)
   );

   priority_encoder_rr #(.N(8), .MODE(1)) dut_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_fp_valid"}, {7'd0, ifa.out_valid}, 8'h00);
      check({tag, "_fp_idx"},   {5'd0, ifa.out_idx},   8'h00);
      check({tag, "_fp_pend"},  ifa.pending,           8'h00);
      check({tag, "_rr_valid"}, {7'd0, ifb.out_valid}, 8'h00);
      check({tag, "_rr_idx"},   {5'd0, ifb.out_idx},   8'h00);
      check({tag, "_rr_pend"},  ifb.pending,           8'h00);
   endtask

   // Drive one cycle on DUT d, queue the expected post-edge state, then compare.
   task automatic cyc(input int d, input logic [7:0] rq, input logic en, input logic clr,
                      input logic rdy, input logic ev, input logic [2:0] ei,
                      input logic [7:0] ep);
      exp_t e;
      if (d == 0) begin
         ifa.req = rq; ifa.enable = en; ifa.clear = clr; ifa.out_ready = rdy;
      end else begin
         ifb.req = rq; ifb.enable = en; ifb.clear = clr; ifb.out_ready = rdy;
      end
      e.dut = d; e.valid = ev; e.idx = ei; e.pend = ep;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      step_no++;
      e = sb_q.pop_front();
      if (e.dut == 0) begin
         check($sformatf("fp_valid#%0d", step_no), {7'd0, ifa.out_valid}, {7'd0, e.valid});
         check($sformatf("fp_idx#%0d", step_no),   {5'd0, ifa.out_idx},   {5'd0, e.idx});
         check($sformatf("fp_pend#%0d", step_no),  ifa.pending,           e.pend);
      end else begin
         check($sformatf("rr_valid#%0d", step_no), {7'd0, ifb.out_valid}, {7'd0, e.valid});
         check($sformatf("rr_idx#%0d", step_no),   {5'd0, ifb.out_idx},   {5'd0, e.idx});
         check($sformatf("rr_pend#%0d", step_no),  ifb.pending,           e.pend);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      step_no = 0;
      rst_n   = 1'b0;
      ifa.req = 8'h00; ifa.enable = 1'b1; ifa.clear = 1'b0; ifa.out_ready = 1'b1;
      ifb.req = 8'h00; ifb.enable = 1'b1; ifb.clear = 1'b0; ifb.out_ready = 1'b1;
      #2;
      check_zero("reset");
      #10;
      rst_n = 1'b1;

      // Fixed priority: one-shot burst drains highest first.
      cyc(0, 8'hA4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h24);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h04);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00);

      // Stall: held grant stable, new bits (including the held index) accumulate.
      cyc(0, 8'h10, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h00);
      cyc(0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'h03);
      cyc(0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'h43);
      cyc(0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4, 8'h53);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h13);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h03);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'h01);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

      // enable=0: only the pending bit drains, req is ignored.
      cyc(0, 8'h30, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h10);
      cyc(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h00);
      cyc(0, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00);

      // clear overrides a simultaneous request and flushes pending.
      cyc(0, 8'h0C, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'h04);
      cyc(0, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 8'h00);
      cyc(0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
      cyc(0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);

      // Round-robin with all requests held: 0..7 then wrap to 0.
      for (int k = 0; k < 9; k++) begin
         logic [7:0] one;
         one = 8'h01 << (k % 8);
         cyc(1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 3'(k % 8), ~one);
      end
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 8'hFC);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'hF8);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 8'hF0);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'hE0);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'hC0);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h80);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h00);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00);

      // Round-robin fairness: a re-requested bit waits behind the other one.
      cyc(1, 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h20);
      cyc(1, 8'h04, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 8'h04);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 8'h00);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00);

      // Asynchronous reset between edges with work pending.
      cyc(1, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 8'h80);
      ifb.req = 8'h00;
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_rst");
      #2;
      rst_n = 1'b1;
      cyc(1, 8'h90, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 8'h80);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 3'd7, 8'h00);
      cyc(1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 3'd7, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
